// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and frame-format constants for the program loader
package prog_loader_pkg;

    // Loader sequencing. CHK is only entered when the trailing checksum byte is enabled.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        HI   = 3'd3,
        LO   = 3'd4,
        WR   = 3'd5,
        CHK  = 3'd6,
        DONE = 3'd7
    } state_t;

    // HDR0 layout: bit 7 selects instruction vs data memory, low bits carry word count minus one.
    localparam int HDR_TYPE_BIT    = 7;
    localparam int HDR_CNT_LSB     = 0;
    localparam int HDR_CNT_MSB_MAX = 6;

    // Payload words arrive high byte first: word = {hi, lo}.
    localparam logic PAYLOAD_HI_FIRST = 1'b1;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader packing host bytes into 16-bit memory writes
//
// Purpose: accepts a framed byte stream (HDR0, HDR1, 2*N payload bytes, optional CHK),
// pairs payload bytes into words and writes them to consecutive memory addresses while
// holding the CPU off.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   - frame ends with an XOR checksum byte over the payload; mismatch sets error
//   undefined - no checksum byte; the byte after the payload starts the next frame
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        frame start (sampled in IDLE) and frame cancel
//   in_valid, in_data   host byte stream; in_ready accepts (transfer = in_valid & in_ready)
//   load                one-cycle write strobe, with is_instruction/load_address/cpu_input
//   busy, cpu_hold      frame in progress (cpu_hold mirrors busy)
//   done                one-cycle end-of-frame pulse
//   error               sticky abort/checksum flag, cleared when the next start is accepted
module program_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  load,
    output logic                  is_instruction,
    output logic [ADDR_WIDTH-1:0] load_address,
    output logic [15:0]           cpu_input,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic                  type_q;
    logic [ADDR_WIDTH-1:0] cnt_q;   // words remaining after the current one
    logic [ADDR_WIDTH-1:0] addr_q;  // address of the next word to be written
    logic [7:0]            hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic xfer;

    // Byte-accepting states are exactly the header, payload and checksum states.
    assign in_ready = (state == HDR0) || (state == HDR1) || (state == HI) ||
                      (state == LO)   || (state == CHK);
    assign xfer     = in_valid && in_ready;
    assign cpu_hold = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            type_q         <= 1'b0;
            cnt_q          <= '0;
            addr_q         <= '0;
            hi_q           <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
            load           <= 1'b0;
            is_instruction <= 1'b0;
            load_address   <= '0;
            cpu_input      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;

            // busy is low in IDLE and DONE, so this covers every in-frame state. In WR the
            // strobe is already on the bus, so the write completes before returning to IDLE.
            if (abort && busy) begin
                state <= IDLE;
                busy  <= 1'b0;
                error <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= HDR0;
                            busy   <= 1'b1;
                            error  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum_q <= '0;
`endif
                        end
                    end
                    HDR0: begin
                        if (xfer) begin
                            type_q <= in_data[HDR_TYPE_BIT];
                            cnt_q  <= in_data[HDR_CNT_LSB +: ADDR_WIDTH];
                            state  <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (xfer) begin
                            addr_q <= in_data[ADDR_WIDTH-1:0];
                            state  <= HI;
                        end
                    end
                    HI: begin
                        if (xfer) begin
                            hi_q   <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum_q <= csum_q ^ in_data;
`endif
                            state  <= LO;
                        end
                    end
                    LO: begin
                        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum_q         <= csum_q ^ in_data;
`endif
                            load           <= 1'b1;
                            is_instruction <= type_q;
                            load_address   <= addr_q;
                            cpu_input      <= PAYLOAD_HI_FIRST ? {hi_q, in_data} : {in_data, hi_q};
                            state          <= WR;
                        end
                    end
                    WR: begin
                        addr_q <= addr_q + ADDR_ONE;
                        if (cnt_q == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q - ADDR_ONE;
                            state <= HI;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (xfer) begin
                            if (in_data != csum_q) begin
                                error <= 1'b1;
                            end
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
